// File: rtl/cpu_oci_dct_packer.sv
// cpu_oci_dct_packer
//   Packs 2-bit direct control-flow trace codes from the retire stage into a
//   DEPTH-slot accumulator. A full or flushed accumulator is moved into a
//   one-entry output register and presented as a frame on a valid/ready port.
//   A halt starts an end-of-test drain. The drain force-flushes the accumulator.
//   It reports completion once every frame has been accepted.
// Ports
//   clk, reset_n              clock, async active-low reset
//   code_valid, code          incoming trace code
//   flush                     single-cycle request to emit the partial buffer
//   halt                      level, starts the end-of-test drain
//   frame_ready/frame_valid   downstream handshake
//   frame_data, frame_count   packed frame (code k at [2k+1:2k]) and its size
//   dct_buffer, dct_count     live accumulator contents and count
//   overflow                  sticky dropped-code flag
//   test_ending/test_has_ended  drain in progress or complete / drain complete
module cpu_oci_dct_packer #(
    parameter int DEPTH  = 15,
    parameter int CODE_W = 2,
    localparam int BUF_W = DEPTH * CODE_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             code_valid,
    input  logic [CODE_W-1:0] code,
    input  logic             flush,
    input  logic             halt,
    input  logic             frame_ready,
    output logic             frame_valid,
    output logic [BUF_W-1:0] frame_data,
    output logic [3:0]       frame_count,
    output logic [BUF_W-1:0] dct_buffer,
    output logic [3:0]       dct_count,
    output logic             overflow,
    output logic             test_ending,
    output logic             test_has_ended
);

    typedef enum logic [1:0] {RUN, ENDING, ENDED} state_e;

    state_e           state_q, state_d;
    logic [BUF_W-1:0] acc_q, acc_d, out_data_q, out_data_d;
    logic [3:0]       cnt_q, cnt_d, out_cnt_q, out_cnt_d;
    logic             out_vld_q, out_vld_d, ovf_q, ovf_d, pend_q, pend_d;

    logic [BUF_W-1:0] ext_buf;
    logic [3:0]       ext_cnt;
    logic             out_free, code_in, trig_full, flush_req, trig_flush, form;

    always_comb begin
        // Output register can take a frame if empty or being drained now.
        out_free   = !out_vld_q || frame_ready;
        code_in    = code_valid && (state_q == RUN) && (cnt_q != 4'(DEPTH));
        // Accumulator as it would look with this cycle's code appended.
        ext_buf    = acc_q;
        ext_cnt    = cnt_q;
        if (code_in) begin
            ext_buf[cnt_q*CODE_W +: CODE_W] = code;
            ext_cnt = cnt_q + 4'd1;
        end
        trig_full  = code_in && (ext_cnt == 4'(DEPTH));
        // Drain states force a flush; a stalled flush is retried via pend_q.
        flush_req  = flush || pend_q || (state_q != RUN);
        trig_flush = flush_req && (ext_cnt != 4'd0);
        form       = trig_full || trig_flush;

        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_cnt_d  = out_cnt_q;
        out_vld_d  = out_vld_q;
        ovf_d      = ovf_q;
        pend_d     = pend_q;
        state_d    = state_q;

        if (form && out_free) begin
            out_data_d = ext_buf;
            out_cnt_d  = ext_cnt;
            out_vld_d  = 1'b1;
            acc_d      = '0;
            cnt_d      = 4'd0;
            pend_d     = 1'b0;
        end else begin
            if (out_vld_q && frame_ready) out_vld_d = 1'b0;
            if (form) begin
                // Stalled: remember a flush; a completing code is dropped
                // so the accumulator keeps its DEPTH-1 codes.
                pend_d = flush || pend_q;
                if (trig_full) begin
                    ovf_d = 1'b1;
                end else begin
                    acc_d = ext_buf;
                    cnt_d = ext_cnt;
                end
            end else begin
                acc_d  = ext_buf;
                cnt_d  = ext_cnt;
                pend_d = 1'b0;
            end
        end

        if (code_valid && (state_q == RUN) && (cnt_q == 4'(DEPTH))) ovf_d = 1'b1;

        case (state_q)
            RUN:     if (halt) state_d = ENDING;
            ENDING:  if ((cnt_q == 4'd0) && !out_vld_q) state_d = ENDED;
            default: state_d = ENDED;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            acc_q      <= '0;
            cnt_q      <= 4'd0;
            out_data_q <= '0;
            out_cnt_q  <= 4'd0;
            out_vld_q  <= 1'b0;
            ovf_q      <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_cnt_q  <= out_cnt_d;
            out_vld_q  <= out_vld_d;
            ovf_q      <= ovf_d;
            pend_q     <= pend_d;
        end
    end

    assign frame_valid    = out_vld_q;
    assign frame_data     = out_data_q;
    assign frame_count    = out_cnt_q;
    assign dct_buffer     = acc_q;
    assign dct_count      = cnt_q;
    assign overflow       = ovf_q;
    assign test_ending    = (state_q != RUN);
    assign test_has_ended = (state_q == ENDED);

endmodule

// File: tb/tb_cpu_oci_dct_packer.sv
// Testbench for cpu_oci_dct_packer: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_cpu_oci_dct_packer;
    localparam int DEPTH = 15;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        code_valid = 1'b0, flush = 1'b0, halt = 1'b0, frame_ready = 1'b0;
    logic [1:0]  code = 2'd0;
    logic        frame_valid, overflow, test_ending, test_has_ended;
    logic [29:0] frame_data, dct_buffer;
    logic [3:0]  frame_count, dct_count;

    cpu_oci_dct_packer dut (
        .clk(clk), .reset_n(reset_n), .code_valid(code_valid), .code(code),
        .flush(flush), .halt(halt), .frame_ready(frame_ready),
        .frame_valid(frame_valid), .frame_data(frame_data), .frame_count(frame_count),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .overflow(overflow),
        .test_ending(test_ending), .test_has_ended(test_has_ended)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: accumulator is a queue of codes, output register is
    // (valid, data, count), state 0=run 1=ending 2=ended.
    int acc[$];
    bit m_fv, m_ovf, m_pend;
    int m_fd, m_fc, m_st;

    function automatic int pack(input int q[$]);
        int v = 0;
        foreach (q[k]) v += q[k] << (2 * k);
        return v;
    endfunction

    task automatic model_reset();
        acc.delete();
        m_fv = 0; m_ovf = 0; m_pend = 0; m_fd = 0; m_fc = 0; m_st = 0;
    endtask

    task automatic model_step();
        int  tmp[$];
        bit  took, full, fl, free, old_fv;
        int  old_n;
        free = !m_fv || frame_ready;
        old_n = acc.size();
        old_fv = m_fv;
        tmp = acc;
        took = 0;
        if (code_valid && m_st == 0) begin
            if (tmp.size() < DEPTH) begin tmp.push_back(int'(code)); took = 1; end
            else m_ovf = 1;
        end
        full = took && tmp.size() == DEPTH;
        fl = (flush || m_pend || m_st != 0) && tmp.size() > 0;
        if (full || fl) begin
            if (free) begin
                m_fd = pack(tmp); m_fc = tmp.size(); m_fv = 1; acc.delete(); m_pend = 0;
            end else begin
                m_pend = flush || m_pend;
                if (full) m_ovf = 1;
                else acc = tmp;
            end
        end else begin
            acc = tmp;
            m_pend = 0;
            if (m_fv && frame_ready) m_fv = 0;
        end
        if (m_st == 0 && halt) m_st = 1;
        else if (m_st == 1 && old_n == 0 && !old_fv) m_st = 2;
    endtask

    task automatic compare();
        chk("frame_valid", frame_valid, m_fv);
        chk("frame_data", frame_data, m_fd);
        chk("frame_count", frame_count, m_fc);
        chk("dct_buffer", dct_buffer, pack(acc));
        chk("dct_count", dct_count, acc.size());
        chk("overflow", overflow, m_ovf);
        chk("test_ending", test_ending, m_st != 0);
        chk("test_has_ended", test_has_ended, m_st == 2);
    endtask

    task automatic drive(input bit cv, input int c, input bit f, input bit h, input bit r);
        code_valid = cv; code = 2'(c); flush = f; halt = h; frame_ready = r;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1 model_reset();
        compare();
        chk("async_fv_low", frame_valid, 1'b0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        compare();
        reset_n = 1'b1;

        // 1: fifteen taken codes make one full frame
        repeat (DEPTH) begin drive(1, 1, 0, 0, 1); cycle(); end
        chk("t1_data", frame_data, 30'h15555555);
        chk("t1_count", frame_count, 4'd15);
        chk("t1_dcnt", dct_count, 4'd0);
        drive(0, 0, 0, 0, 1); cycle();

        // 2: three codes then flush
        drive(1, 0, 0, 0, 1); cycle();
        drive(1, 1, 0, 0, 1); cycle();
        drive(1, 2, 0, 0, 1); cycle();
        drive(0, 0, 1, 0, 1); cycle();
        chk("t2_valid", frame_valid, 1'b1);
        chk("t2_data", frame_data, 30'h24);
        chk("t2_count", frame_count, 4'd3);
        drive(0, 0, 0, 0, 1); cycle();

        // 3: hold a frame, then fifteen more codes
        drive(1, 3, 1, 0, 0); cycle();
        repeat (DEPTH) begin drive(1, $urandom_range(0, 3), 0, 0, 0); cycle(); end
        chk("t3_ovf", overflow, 1'b1);
        chk("t3_dcnt", dct_count, 4'd14);
        chk("t3_held_data", frame_data, 30'h3);
        chk("t3_held_cnt", frame_count, 4'd1);

        // 4: stalled flush retried until the register frees up
        drive(0, 0, 1, 0, 0); cycle();
        drive(0, 0, 0, 0, 0); cycle();
        chk("t4_dcnt_kept", dct_count, 4'd14);
        drive(0, 0, 0, 0, 1); cycle();
        chk("t4_valid", frame_valid, 1'b1);
        chk("t4_count", frame_count, 4'd14);
        chk("t4_dcnt", dct_count, 4'd0);
        drive(0, 0, 0, 0, 1); cycle();

        // 5: halt drains a 5-code accumulator
        do_reset();
        repeat (5) begin drive(1, 1, 0, 0, 1); cycle(); end
        drive(0, 0, 0, 1, 1); cycle();
        chk("t5_ending", test_ending, 1'b1);
        drive(1, 2, 0, 1, 1); cycle();
        chk("t5_fcnt", frame_count, 4'd5);
        chk("t5_fv", frame_valid, 1'b1);
        repeat (4) begin drive(1, 2, 0, 0, 1); cycle(); end
        chk("t5_ended", test_has_ended, 1'b1);
        chk("t5_dcnt", dct_count, 4'd0);

        // 6: reset while a frame is pending
        do_reset();
        repeat (DEPTH) begin drive(1, $urandom_range(0, 3), 0, 0, 0); cycle(); end
        chk("t6_fv_before", frame_valid, 1'b1);
        do_reset();
        repeat (3) begin drive(1, 1, 0, 0, 1); cycle(); end
        drive(0, 0, 1, 0, 1); cycle();
        chk("t6_after_count", frame_count, 4'd3);

        // Random episodes, each ending in a drain and reset
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                drive(($urandom % 4) != 0, $urandom_range(0, 3), ($urandom % 8) == 0,
                      c > 240 + ep * 5,
                      (ep % 2 == 0) ? (($urandom % 3) != 0) : (($urandom % 4) == 0));
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
